// File: rtl/fizzbuzz_pkg.sv
// fizzbuzz_pkg: shared state, line-kind, LIMIT-range and BCD helper definitions for fizzbuzz_ctrl
package fizzbuzz_pkg;
  typedef enum logic [2:0] {S_IDLE, S_INC, S_SETTLE, S_EMIT, S_DONE} state_t;
  localparam logic [1:0] KIND_NUM = 2'd0;
  localparam logic [1:0] KIND_FIZZ = 2'd1;
  localparam logic [1:0] KIND_BUZZ = 2'd2;
  localparam logic [1:0] KIND_FIZZBUZZ = 2'd3;
  localparam int LIMIT_MIN = 1;
  localparam int LIMIT_MAX = 999;
  function automatic logic [9:0] bcd2bin(input logic [3:0] d2, input logic [3:0] d1, input logic [3:0] d0);
    return 10'(d2) * 10'd100 + 10'(d1) * 10'd10 + 10'(d0);
  endfunction
endpackage

// File: rtl/fizzbuzz_ctrl_mod_counter.sv
// mod_counter: wrap-around modulo-M counter that advances when en is high
module mod_counter #(
  parameter int M = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  output logic [$clog2(M)-1:0] cnt
);
  localparam int W = $clog2(M);
  localparam logic [W-1:0] TOP = W'(M - 1);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = !en ? cnt_q : (cnt_q == TOP) ? '0 : cnt_q + W'(1);
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/fizzbuzz_ctrl.sv
// fizzbuzz_ctrl: FizzBuzz line sequencer over an external BCD counter; FIZZBUZZ_CHECK_EN adds a BCD-vs-binary checker on err
module fizzbuzz_ctrl
  import fizzbuzz_pkg::*;
#(
  parameter int LIMIT = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] digit2,
  input  logic [3:0] digit1,
  input  logic [3:0] digit0,
  output logic       increment,
  output logic       line_valid,
  input  logic       line_ready,
  output logic [1:0] line_kind,
  output logic [3:0] line_d2,
  output logic [3:0] line_d1,
  output logic [3:0] line_d0,
  output logic       busy,
  output logic       done,
  output logic       err
);
  if (LIMIT < LIMIT_MIN || LIMIT > LIMIT_MAX) begin : g_bad_limit
    $error("fizzbuzz_ctrl: LIMIT must be within 1..999");
  end
  localparam logic [9:0] LIM = 10'(LIMIT);
  state_t state_q, state_d;
  logic [9:0] n_q, n_d;
  logic [1:0] kind_q, kind_d;
  logic [3:0] d2_q, d2_d, d1_q, d1_d, d0_q, d0_d;
  logic [1:0] mod3;
  logic [2:0] mod5;
  logic inc, m3z, m5z;
  assign inc = state_q == S_INC;
  assign m3z = mod3 == 2'd0;
  assign m5z = mod5 == 3'd0;
  mod_counter #(.M(3)) u_mod3 (.clk(clk), .rst(rst), .en(inc), .cnt(mod3));
  mod_counter #(.M(5)) u_mod5 (.clk(clk), .rst(rst), .en(inc), .cnt(mod5));
  always_comb begin
    state_d = state_q;
    n_d = inc ? n_q + 10'd1 : n_q;
    kind_d = kind_q;
    d2_d = d2_q;
    d1_d = d1_q;
    d0_d = d0_q;
    case (state_q)
      S_IDLE: state_d = start ? S_INC : S_IDLE;
      S_INC: state_d = S_SETTLE;
      S_SETTLE: begin
        state_d = S_EMIT;
        kind_d = (m3z && m5z) ? KIND_FIZZBUZZ : m3z ? KIND_FIZZ : m5z ? KIND_BUZZ : KIND_NUM;
        d2_d = digit2;
        d1_d = digit1;
        d0_d = digit0;
      end
      S_EMIT: state_d = !line_ready ? S_EMIT : (n_q == LIM) ? S_DONE : S_INC;
      default: state_d = state_q;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      n_q <= '0;
      kind_q <= KIND_NUM;
      d2_q <= '0;
      d1_q <= '0;
      d0_q <= '0;
    end else begin
      state_q <= state_d;
      n_q <= n_d;
      kind_q <= kind_d;
      d2_q <= d2_d;
      d1_q <= d1_d;
      d0_q <= d0_d;
    end
  end
  assign increment = inc;
  assign line_valid = state_q == S_EMIT;
  assign busy = state_q == S_INC || state_q == S_SETTLE || state_q == S_EMIT;
  assign done = state_q == S_DONE;
  assign line_kind = kind_q;
  assign line_d2 = d2_q;
  assign line_d1 = d1_q;
  assign line_d0 = d0_q;
`ifdef FIZZBUZZ_CHECK_EN
  logic chk_q, chk_d, err_q, err_d;
  always_comb begin
    chk_d = state_q == S_SETTLE && bcd2bin(digit2, digit1, digit0) != n_q;
    err_d = err_q | chk_q;
  end
  always_ff @(posedge clk) begin
    chk_q <= rst ? 1'b0 : chk_d;
    err_q <= rst ? 1'b0 : err_d;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_fizzbuzz_ctrl.sv
// tb_fizzbuzz_ctrl: scoreboard bench for fizzbuzz_ctrl with behavioural BCD counters for LIMIT 15, 100 and 1
module tb_fizzbuzz_ctrl;
  import fizzbuzz_pkg::*;
  typedef struct packed {logic [1:0] k; logic [11:0] v;} exp_t;
`ifdef FIZZBUZZ_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif
  logic clk = 1'b0, rst, start, ready15, corrupt;
  logic [11:0] bcd15, bcd100, bcd1;
  logic [3:0] dig0_15;
  logic inc15, v15, busy15, done15, err15;
  logic [1:0] k15;
  logic [3:0] a2, a1, a0;
  logic inc100, v100, busy100, done100, err100;
  logic [1:0] k100;
  logic [3:0] b2, b1, b0;
  logic inc1, v1, busy1, done1, err1;
  logic [1:0] k1;
  logic [3:0] c2, c1, c0;
  int n_cmp = 0, n_bad = 0, hs_cnt = 0, inc_cnt = 0, hs1 = 0;
  int kc [4] = '{0, 0, 0, 0};
  logic [13:0] last100 = '0, last1 = '0;
  logic pend_done = 1'b0;
  logic [1:0] kt [15] = '{0, 0, 1, 0, 2, 1, 0, 0, 1, 2, 0, 1, 0, 0, 3};
  exp_t q [$];
  exp_t e;
  always #5 clk = ~clk;
  assign dig0_15 = (corrupt && bcd15 == 12'h004) ? 4'd5 : bcd15[3:0];
  fizzbuzz_ctrl #(.LIMIT(15)) dut15 (.clk(clk), .rst(rst), .start(start), .digit2(bcd15[11:8]), .digit1(bcd15[7:4]), .digit0(dig0_15), .increment(inc15), .line_valid(v15), .line_ready(ready15), .line_kind(k15), .line_d2(a2), .line_d1(a1), .line_d0(a0), .busy(busy15), .done(done15), .err(err15));
  fizzbuzz_ctrl #(.LIMIT(100)) dut100 (.clk(clk), .rst(rst), .start(start), .digit2(bcd100[11:8]), .digit1(bcd100[7:4]), .digit0(bcd100[3:0]), .increment(inc100), .line_valid(v100), .line_ready(1'b1), .line_kind(k100), .line_d2(b2), .line_d1(b1), .line_d0(b0), .busy(busy100), .done(done100), .err(err100));
  fizzbuzz_ctrl #(.LIMIT(1)) dut1 (.clk(clk), .rst(rst), .start(start), .digit2(bcd1[11:8]), .digit1(bcd1[7:4]), .digit0(bcd1[3:0]), .increment(inc1), .line_valid(v1), .line_ready(1'b1), .line_kind(k1), .line_d2(c2), .line_d1(c1), .line_d0(c0), .busy(busy1), .done(done1), .err(err1));
  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [3:0] h, t, o;
    {h, t, o} = v;
    if (o != 4'd9) o = o + 4'd1;
    else begin
      o = 4'd0;
      if (t != 4'd9) t = t + 4'd1;
      else begin
        t = 4'd0;
        h = (h == 4'd9) ? 4'd0 : h + 4'd1;
      end
    end
    return {h, t, o};
  endfunction
  always @(posedge clk) begin
    bcd15 <= rst ? '0 : inc15 ? bcd_inc(bcd15) : bcd15;
    bcd100 <= rst ? '0 : inc100 ? bcd_inc(bcd100) : bcd100;
    bcd1 <= rst ? '0 : inc1 ? bcd_inc(bcd1) : bcd1;
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out", name);
  endtask
  task automatic push_lines(input logic bad4);
    for (int i = 1; i <= 15; i++) begin
      e.k = kt[i-1];
      e.v = {4'(i / 100), 4'((i / 10) % 10), 4'(i % 10)};
      if (bad4 && i == 4) e.v[3:0] = 4'd5;
      q.push_back(e);
    end
  endtask
  task automatic check_reset(input string tag);
    check({tag, "_inc"}, inc15, 0);
    check({tag, "_valid"}, v15, 0);
    check({tag, "_busy"}, busy15, 0);
    check({tag, "_done"}, done15, 0);
    check({tag, "_err"}, err15, 0);
    check({tag, "_kind"}, k15, KIND_NUM);
    check({tag, "_digits"}, {a2, a1, a0}, 0);
  endtask
  task automatic wait_hs(input int t);
    int i = 0;
    while (hs_cnt < t && i < 400) begin
      @(posedge clk);
      #2;
      i++;
    end
    if (hs_cnt < t) timeout("wait_handshake");
  endtask
  task automatic wait_valid();
    int i = 0;
    while (!v15 && i < 50) begin
      @(posedge clk);
      #2;
      i++;
    end
    if (!v15) timeout("wait_valid");
  endtask
  task automatic wait_done15();
    int i = 0;
    while (!done15 && i < 400) begin
      @(posedge clk);
      #2;
      i++;
    end
    if (!done15) timeout("wait_done15");
  endtask
  task automatic wait_done100();
    int i = 0;
    while (!done100 && i < 1000) begin
      @(posedge clk);
      #2;
      i++;
    end
    if (!done100) timeout("wait_done100");
  endtask
  always @(negedge clk) begin
    if (pend_done) begin
      check("done_after_last", done15, 1);
      pend_done = 1'b0;
    end
    if (!rst && v15 && ready15) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL line_unexpected: got %0h expected none", {k15, a2, a1, a0});
      end else begin
        e = q.pop_front();
        check("line", {k15, a2, a1, a0}, {e.k, e.v});
        if (e.v == 12'h015) begin
          check("done_at_last", done15, 0);
          pend_done = 1'b1;
        end
      end
      hs_cnt++;
    end
    if (!rst && inc15) inc_cnt++;
    if (!rst && v100) begin
      kc[k100]++;
      last100 = {k100, b2, b1, b0};
    end
    if (!rst && v1) begin
      hs1++;
      last1 = {k1, c2, c1, c0};
    end
  end
  initial begin
    rst = 1'b1;
    start = 1'b0;
    ready15 = 1'b1;
    corrupt = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check_reset("reset");
    rst = 1'b0;
    push_lines(1'b1);
    @(posedge clk);
    #2;
    start = 1'b1;
    @(posedge clk);
    #2;
    check("inc_pulse", inc15, 1);
    check("busy_inc", busy15, 1);
    @(posedge clk);
    #2;
    check("settle_inc_low", inc15, 0);
    check("settle_no_valid", v15, 0);
    @(posedge clk);
    #2;
    check("valid_rise", v15, 1);
    wait_hs(2);
    ready15 = 1'b0;
    wait_valid();
    for (int i = 0; i < 7; i++) begin
      check("stall_valid", v15, 1);
      check("stall_line", {k15, a2, a1, a0}, {KIND_FIZZ, 12'h003});
      check("stall_no_inc", inc15, 0);
      @(posedge clk);
      #2;
    end
    check("stall_inc_count", inc_cnt, 3);
    ready15 = 1'b1;
    wait_hs(3);
    check("err_before_4", err15, 0);
    wait_hs(5);
    check("err_after_4", err15, EXP_ERR);
    wait_done15();
    check("run1_handshakes", hs_cnt, 15);
    check("run1_incs", inc_cnt, 15);
    check("run1_queue_empty", q.size(), 0);
    check("run1_busy", busy15, 0);
    check("run1_err", err15, EXP_ERR);
    repeat (20) @(posedge clk);
    #2;
    check("hold_done", done15, 1);
    check("hold_busy", busy15, 0);
    check("hold_no_restart", hs_cnt, 15);
    start = 1'b0;
    wait_done100();
    check("l100_num", kc[0], 53);
    check("l100_fizz", kc[1], 27);
    check("l100_buzz", kc[2], 14);
    check("l100_fizzbuzz", kc[3], 6);
    check("l100_last", last100, {KIND_BUZZ, 12'h100});
    check("l100_busy", busy100, 0);
    check("l1_lines", hs1, 1);
    check("l1_line", last1, {KIND_NUM, 12'h001});
    check("l1_done", done1, 1);
    rst = 1'b1;
    corrupt = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    q.delete();
    hs_cnt = 0;
    inc_cnt = 0;
    push_lines(1'b0);
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    wait_hs(6);
    ready15 = 1'b0;
    wait_valid();
    check("line7_held", {k15, a2, a1, a0}, {KIND_NUM, 12'h007});
    rst = 1'b1;
    @(posedge clk);
    #2;
    check_reset("midrst");
    rst = 1'b0;
    q.delete();
    hs_cnt = 0;
    inc_cnt = 0;
    ready15 = 1'b1;
    push_lines(1'b0);
    @(posedge clk);
    #2;
    check("idle_after_rst", busy15, 0);
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    wait_hs(3);
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    wait_done15();
    check("run2_handshakes", hs_cnt, 15);
    check("run2_incs", inc_cnt, 15);
    check("run2_queue_empty", q.size(), 0);
    check("run2_err", err15, 0);
    @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
